// File: rtl/uart_rx_datapath_pkg.sv
// Shared constants and types for the UART receive datapath.
package uart_rx_datapath_pkg;

  // Bits captured after the start bit: up to 8 data, optional parity, stop.
  localparam int unsigned RX_FRAME_W = 10;

  // Idle line is all ones; used as the shift register reset value.
  localparam logic [RX_FRAME_W-1:0] RX_IDLE = 10'h3FF;

  // Decoded view of the captured frame.
  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       perr;
  } rx_frame_t;

endpackage

// File: rtl/uart_rx_datapath_rx_remap.sv
// Combinational remap of the raw shift register into data/parity/stop fields.
module rx_remap
  import uart_rx_datapath_pkg::*;
(
  input  logic [RX_FRAME_W-1:0] sh_i,
  input  logic                  eight_i,
  input  logic                  pen_i,
  input  logic                  ohel_i,
  output rx_frame_t             frame_o
);

  logic [7:0] data;
  logic       par;
  logic       exp_par;

  // Pick the field positions; the last-received bits sit at the MSB end.
  always_comb begin
    data = 8'h00;
    par  = 1'b0;
    unique case ({eight_i, pen_i})
      2'b11: begin
        data = sh_i[7:0];
        par  = sh_i[8];
      end
      2'b10: data = sh_i[8:1];
      2'b01: begin
        data = {1'b0, sh_i[7:1]};
        par  = sh_i[8];
      end
      2'b00: data = {1'b0, sh_i[8:2]};
    endcase
  end

  // Bit 7 is forced to 0 in 7-bit mode, so XOR over all 8 bits is valid for both widths.
  always_comb begin
    exp_par      = (^data) ^ ohel_i;
    frame_o.data = data;
    frame_o.par  = par;
    frame_o.stop = sh_i[9];
    frame_o.perr = pen_i & (par ^ exp_par);
  end

endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: serial shift register, frame remap and sticky status flags.
module uart_rx_datapath
  import uart_rx_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       BTU,
  input  logic       START,
  input  logic       RX,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       DONE,
  input  logic       CLR,
  output logic [7:0] REMAP_OUT,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);

  logic [RX_FRAME_W-1:0] sh_q, sh_d;
  logic                  rxrdy_q, rxrdy_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovf_q, ovf_d;
  rx_frame_t             frame;

  rx_remap u_rx_remap (
    .sh_i    (sh_q),
    .eight_i (EIGHT),
    .pen_i   (PEN),
    .ohel_i  (OHEL),
    .frame_o (frame)
  );

  // Right shift one bit per bit time; held while the start bit is being validated.
  always_comb begin
    sh_d = sh_q;
    if (BTU && !START) begin
      sh_d = {RX, sh_q[RX_FRAME_W-1:1]};
    end
  end

  // Sticky flags: a DONE set takes priority over a same-cycle CLR.
  always_comb begin
    rxrdy_d = DONE                     | (rxrdy_q & ~CLR);
    perr_d  = (DONE & frame.perr)      | (perr_q  & ~CLR);
    ferr_d  = (DONE & ~frame.stop)     | (ferr_q  & ~CLR);
    ovf_d   = (DONE & rxrdy_q)         | (ovf_q   & ~CLR);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= RX_IDLE;
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      rxrdy_q <= rxrdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign REMAP_OUT = frame.data;
  assign RXRDY     = rxrdy_q;
  assign PERR      = perr_q;
  assign FERR      = ferr_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath: directed vectors, corner sequences, random vs model.
module tb_uart_rx_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btu = 1'b0, start = 1'b0, rx = 1'b1;
  logic       eight = 1'b1, pen = 1'b1, ohel = 1'b0;
  logic       done = 1'b0, clr = 1'b0;
  logic [7:0] remap_out;
  logic       rxrdy, perr, ferr, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .BTU       (btu),
    .START     (start),
    .RX        (rx),
    .EIGHT     (eight),
    .PEN       (pen),
    .OHEL      (ohel),
    .DONE      (done),
    .CLR       (clr),
    .REMAP_OUT (remap_out),
    .RXRDY     (rxrdy),
    .PERR      (perr),
    .FERR      (ferr),
    .OVF       (ovf)
  );

  typedef struct {
    bit         e;
    bit         p;
    bit         o;
    int         nbits;
    logic [9:0] bits;   // bit 0 is sent first
    logic [7:0] remap;
    bit         perr;
    bit         ferr;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(bit e, bit p, bit o, int n, logic [9:0] b, logic [7:0] r,
                              bit pe, bit fe);
    vec_t v;
    v.e = e; v.p = p; v.o = o; v.nbits = n; v.bits = b; v.remap = r; v.perr = pe; v.ferr = fe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    eight = v.e; pen = v.p; ohel = v.o;
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < v.nbits; i++) begin
      btu = 1'b1; rx = v.bits[i]; cyc();
    end
    btu = 1'b0; rx = 1'b1;
    chk($sformatf("vec%0d remap", idx), remap_out, v.remap);
    done = 1'b1; cyc(); done = 1'b0;
    chk($sformatf("vec%0d rxrdy", idx), {7'd0, rxrdy}, 8'd1);
    chk($sformatf("vec%0d perr", idx), {7'd0, perr}, {7'd0, v.perr});
    chk($sformatf("vec%0d ferr", idx), {7'd0, ferr}, {7'd0, v.ferr});
    chk($sformatf("vec%0d ovf", idx), {7'd0, ovf}, 8'd0);
  endtask

  // Reference model: the last ten accepted line bits, oldest at index 0.
  bit hist[$];
  bit m_rxrdy, m_perr, m_ferr, m_ovf;

  function automatic logic [7:0] m_data(bit e, bit p);
    int n = e ? 8 : 7;
    int first = 9 - (p ? 1 : 0) - n;
    logic [7:0] d = 8'h00;
    for (int i = 0; i < n; i++) d[i] = hist[first + i];
    return d;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b1);
    m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    logic [7:0] d;
    bit par, stop, bad_par;
    if (rst) begin
      model_reset();
    end else begin
      d       = m_data(eight, pen);
      par     = pen ? hist[8] : 1'b0;
      stop    = hist[9];
      bad_par = pen && (par != ((^d) ^ ohel));
      m_ovf   = (done && m_rxrdy) || (m_ovf && !clr);
      m_rxrdy = done || (m_rxrdy && !clr);
      m_perr  = (done && bad_par) || (m_perr && !clr);
      m_ferr  = (done && !stop) || (m_ferr && !clr);
      if (btu && !start) begin
        hist.push_back(rx);
        void'(hist.pop_front());
      end
    end
  endtask

  initial begin
    vecs[0] = mk(1, 1, 0, 10, 10'h2A5, 8'hA5, 0, 0);
    vecs[1] = mk(1, 1, 0, 10, 10'h3A5, 8'hA5, 1, 0);
    vecs[2] = mk(1, 1, 0, 10, 10'h0A5, 8'hA5, 0, 1);
    vecs[3] = mk(1, 1, 1, 10, 10'h3A5, 8'hA5, 0, 0);
    vecs[4] = mk(0, 0, 0, 8,  10'h0D5, 8'h55, 0, 0);
    vecs[5] = mk(1, 0, 0, 10, 10'h278, 8'h3C, 0, 0);
    vecs[6] = mk(0, 1, 1, 10, 10'h257, 8'h2B, 1, 0);

    // Reset and idle
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle remap", remap_out, 8'hFF);
    chk("idle flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h00);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h00);

    // BTU while START is high must not shift
    run_vec(vecs[4], 4);
    start = 1'b1; rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btu = 1'b1; cyc();
    end
    btu = 1'b0; start = 1'b0; rx = 1'b1;
    chk("start hold remap", remap_out, 8'h55);

    // DONE held high from reset with all-ones frame
    rst = 1'b1; cyc(); rst = 1'b0;
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; rx = 1'b1; done = 1'b1;
    cyc();
    chk("held c1 flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'b0000_1100);
    cyc();
    chk("held c2 ovf", {7'd0, ovf}, 8'd1);
    done = 1'b0;

    // DONE and CLR together while RXRDY is set
    clr = 1'b1; cyc(); clr = 1'b0;
    done = 1'b1; cyc(); done = 1'b0;
    chk("pre-coll ovf", {7'd0, ovf}, 8'd0);
    done = 1'b1; clr = 1'b1; cyc(); done = 1'b0; clr = 1'b0;
    chk("coll rxrdy", {7'd0, rxrdy}, 8'd1);
    chk("coll ovf", {7'd0, ovf}, 8'd1);

    // Reset mid-frame overrides everything
    for (int i = 0; i < 3; i++) begin
      btu = 1'b1; rx = 1'b0; cyc();
    end
    rst = 1'b1; done = 1'b1; cyc();
    rst = 1'b0; done = 1'b0; btu = 1'b0; rx = 1'b1;
    chk("rst flags", {4'd0, rxrdy, perr, ferr, ovf}, 8'h00);
    chk("rst remap8", remap_out, 8'hFF);
    eight = 1'b0; #1;
    chk("rst remap7", remap_out, 8'h7F);

    // Randomized run against the model
    rst = 1'b1; cyc(); rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      btu   = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      rx    = $urandom_range(0, 1);
      done  = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 19) == 0) begin
        eight = $urandom_range(0, 1);
        pen   = $urandom_range(0, 1);
        ohel  = $urandom_range(0, 1);
      end
      @(negedge clk);
      chk("rand remap", remap_out, m_data(eight, pen));
      chk("rand flags", {4'd0, rxrdy, perr, ferr, ovf}, {4'd0, m_rxrdy, m_perr, m_ferr, m_ovf});
      model_edge();
      cyc();
    end
    rst = 1'b0; done = 1'b0; clr = 1'b0; btu = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_datapath.md
# uart_rx_datapath

UART receive datapath. It deserializes RX bits into a 10-bit shift register and remaps the captured frame to a data byte according to the word length and parity configuration. It also raises the receiver status flags RXRDY, PERR, FERR and OVF. It sits between the RX control FSM (which supplies START, BTU and DONE) and the processor-side status/data read interface (which supplies CLR).

## Interface
Parameters: none (frame width fixed at 10 bits after the start bit).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- BTU  in  1  bit-time-up strobe from bit timer; one clk wide
- START  in  1  high while the control FSM is validating the start bit; suppresses shifting
- RX  in  1  serial input (synchronized externally)
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
- PEN  in  1  1 = parity bit present
- OHEL  in  1  parity sense: 1 = odd, 0 = even
- DONE  in  1  frame complete strobe from control FSM
- CLR  in  1  status clear (processor read of data register)
- REMAP_OUT  out  8  received data byte, LSB first-received
- RXRDY  out  1  byte available
- PERR  out  1  parity error
- FERR  out  1  framing error (stop bit = 0)
- OVF  out  1  overflow: new frame completed while RXRDY still set

## Operation
- Shift register SH[9:0]:
  - Reset to 10'h3FF (idle line).
  - When BTU=1 and START=0: SH <= {RX, SH[9:1]} (right shift, new bit into MSB).
  - Otherwise SH holds.
- Remap is combinational from SH, EIGHT and PEN. Fields are data[7:0], par, stop:
  - EIGHT=1, PEN=1: data=SH[7:0], par=SH[8], stop=SH[9]
  - EIGHT=1, PEN=0: data=SH[8:1], par=0, stop=SH[9]
  - EIGHT=0, PEN=1: data={0,SH[7:1]}, par=SH[8], stop=SH[9]
  - EIGHT=0, PEN=0: data={0,SH[8:2]}, par=0, stop=SH[9]
- REMAP_OUT = data; 7-bit mode forces bit 7 to 0.
- Expected parity = XOR of the 7 or 8 valid data bits, XOR OHEL.
- Status flags are all registered and sticky:
  - RXRDY: set on DONE; cleared on CLR.
  - PERR: set on DONE & PEN & (par != expected parity); cleared on CLR.
  - FERR: set on DONE & (stop == 0); cleared on CLR.
  - OVF: set on DONE & RXRDY (value before this edge); cleared on CLR.
- Simultaneous DONE and CLR: the DONE set wins for every flag. Flags not set by this DONE are cleared by the CLR.
- EIGHT, PEN and OHEL are static during a frame. Changing them mid-frame changes the remap immediately; no protection is provided.

## Timing
- Reset values: SH=10'h3FF; RXRDY=PERR=FERR=OVF=0. REMAP_OUT is 8'hFF if EIGHT=1, else 8'h7F.
- One shift per BTU pulse; no shift while START=1.
- REMAP_OUT follows SH combinationally, with zero latency after the final shift edge.
- Flags update on the edge where DONE=1 and are visible the next cycle (latency 1).
- DONE is expected one clk wide. If DONE is held high, every cycle is a new completion: RXRDY sets on the first edge and OVF sets on the second.
- rst asserted mid-frame returns SH and all flags to reset values on the next edge, regardless of the other inputs.

## Structure
- Shared package constants: RX_FRAME_W=10 and RX_IDLE=10'h3FF.
- One combinational sub-module, rx_remap, is natural: it takes SH, EIGHT, PEN and OHEL and produces data, par, stop and parity-error.
- The top level holds the shift register and the flag registers.

## Test plan
- Reset, then hold for 10 cycles with no BTU → REMAP_OUT=8'hFF (EIGHT=1), all flags 0, SH unchanged.
- EIGHT=1, PEN=1, OHEL=0. Shift data 8'hA5 LSB first, then par=0, then stop=1 (10 BTU pulses), then DONE pulse → REMAP_OUT=8'hA5, RXRDY=1, PERR=0, FERR=0, OVF=0. Then CLR → all flags 0.
- Same frame with par=1 → PERR=1. Same frame with stop=0 → FERR=1. With OHEL=1 and par=1 → PERR=0.
- EIGHT=0, PEN=0: shift 8 bits (7'h55 data then stop=1), DONE → REMAP_OUT=8'h55. Repeat with BTU pulses while START=1 → SH unchanged.
- Post-reset with EIGHT=1, PEN=1, RX=1, BTU=0 and DONE held high → cycle 1: RXRDY=1, PERR=1 (all-ones data has even parity 0, received par=1), FERR=0. Cycle 2: OVF=1.
- DONE and CLR in the same cycle while RXRDY=1 → RXRDY stays 1 and OVF=1. Assert rst mid-frame → all flags 0 and SH=10'h3FF.
